pc_unit: RTL and testbench

//   Program-counter stage of the MUSA IF unit; the PC register directly upstream of the Stack.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the PC stage, instruction memory and the return-address Stack.
// master = pc_unit; slave = surrounding pipeline / Stack / memory.
interface pc_unit_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branchTaken;
  logic [ADDR_W-1:0] branchTarget;
  logic              jump;
  logic [ADDR_W-1:0] jumpTarget;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] stackOut;
  logic              stackOverflow;
  logic [ADDR_W-1:0] pc;
  logic              pcValid;
  logic [ADDR_W-1:0] pushAddr;
  logic              writeStack;
  logic              readStack;
  logic              trap;

  modport master (
    input  stall, branchTaken, branchTarget, jump, jumpTarget, call, ret,
    input  stackOut, stackOverflow,
    output pc, pcValid, pushAddr, writeStack, readStack, trap
  );

  modport slave (
    output stall, branchTaken, branchTarget, jump, jumpTarget, call, ret,
    output stackOut, stackOverflow,
    input  pc, pcValid, pushAddr, writeStack, readStack, trap
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter: next-PC select (ret > call > jump > branch > seq), Stack push/pop, one bubble per RET.
// Optional stack-fault trap enabled by defining PC_TRAP_EN.
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                PC_STEP      = 1,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(32'h0000_0100)
) (
  input logic        clock,
  input logic        reset,
  pc_unit_if.master  bus
);

  typedef enum logic {RUN, POP_WAIT} state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rd_stack, wr_stack;

`ifdef PC_TRAP_EN
  logic ovf_q, ovf_d;
  logic trap_q, trap_d;
  logic fault;

  // Only the 0->1 transition matters; the Stack holds its flag until it is reset.
  assign fault = bus.stackOverflow & ~ovf_q;
  assign ovf_d = bus.stackOverflow;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_stack = 1'b0;
    wr_stack = 1'b0;
`ifdef PC_TRAP_EN
    trap_d   = 1'b0;
    if (fault) begin
      pc_d    = TRAP_VECTOR;
      state_d = RUN;
      trap_d  = 1'b1;
    end else
`endif
    if (!bus.stall) begin
      if (state_q == RUN) begin
        if (bus.ret) begin
          rd_stack = 1'b1;
          state_d  = POP_WAIT;
        end else if (bus.call) begin
          wr_stack = 1'b1;
          pc_d     = bus.jumpTarget;
        end else if (bus.jump) begin
          pc_d     = bus.jumpTarget;
        end else if (bus.branchTaken) begin
          pc_d     = bus.branchTarget;
        end else begin
          pc_d     = pc_q + STEP;
        end
      end else begin
        pc_d    = bus.stackOut;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
`ifdef PC_TRAP_EN
      ovf_q   <= 1'b0;
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_TRAP_EN
      ovf_q   <= ovf_d;
      trap_q  <= trap_d;
`endif
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pcValid    = (state_q == RUN) & ~reset;
  assign bus.pushAddr   = pc_q + STEP;
  assign bus.readStack  = rd_stack & ~reset;
  assign bus.writeStack = wr_stack & ~reset;
`ifdef PC_TRAP_EN
  assign bus.trap       = trap_q;
`else
  assign bus.trap       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, sequential fetch, call/ret, stall, priority, fault, wrap.
module tb_pc_unit;
  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge and land 1ns after it, away from the sampling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic no_strobes(input string tag);
    check({tag, "_rd"}, {31'd0, bus.readStack}, 32'd0);
    check({tag, "_wr"}, {31'd0, bus.writeStack}, 32'd0);
  endtask

  initial begin
    bus.stall = 0; bus.branchTaken = 0; bus.branchTarget = '0;
    bus.jump = 0; bus.jumpTarget = '0; bus.call = 0; bus.ret = 0;
    bus.stackOut = '0; bus.stackOverflow = 0;
    reset = 1;
    bus.ret = 1;
    tick(); tick();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", {31'd0, bus.pcValid}, 32'd0);
    check("rst_rd_forced", {31'd0, bus.readStack}, 32'd0);
    check("rst_trap", {31'd0, bus.trap}, 32'd0);
    bus.ret = 0;
    reset = 0;
    settle();
    check("run_valid", {31'd0, bus.pcValid}, 32'd1);

    // sequential fetch
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", bus.pc, 32'(i));
      check("seq_valid", {31'd0, bus.pcValid}, 32'd1);
      no_strobes("seq");
    end

    // call from 0x10 to 0x40
    bus.jump = 1; bus.jumpTarget = 32'h10;
    tick();
    check("jmp_pc", bus.pc, 32'h10);
    bus.jump = 0; bus.call = 1; bus.jumpTarget = 32'h40;
    settle();
    check("call_wr", {31'd0, bus.writeStack}, 32'd1);
    check("call_rd", {31'd0, bus.readStack}, 32'd0);
    check("call_push", bus.pushAddr, 32'h11);
    tick();
    bus.call = 0;
    check("call_pc", bus.pc, 32'h40);
    tick(); tick();
    check("seq_after_call", bus.pc, 32'h42);

    // ret: one bubble, then popped address
    bus.ret = 1;
    settle();
    check("ret_rd", {31'd0, bus.readStack}, 32'd1);
    check("ret_wr", {31'd0, bus.writeStack}, 32'd0);
    tick();
    bus.ret = 0; bus.stackOut = 32'h11;
    settle();
    check("pop_valid", {31'd0, bus.pcValid}, 32'd0);
    check("pop_pc_held", bus.pc, 32'h42);
    no_strobes("pop");
    tick();
    check("ret_pc", bus.pc, 32'h11);
    check("ret_valid", {31'd0, bus.pcValid}, 32'd1);

    // stall holds pc against a pending jump
    bus.jump = 1; bus.jumpTarget = 32'h20;
    tick();
    bus.stall = 1; bus.jumpTarget = 32'h80; bus.call = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      no_strobes("stall");
      tick();
      check("stall_pc", bus.pc, 32'h20);
    end
    bus.stall = 0; bus.call = 0;
    tick();
    bus.jump = 0;
    check("unstall_pc", bus.pc, 32'h80);

    // jump beats branch; branch alone
    bus.jump = 1; bus.jumpTarget = 32'h90; bus.branchTaken = 1; bus.branchTarget = 32'h33;
    tick();
    check("jmp_over_br", bus.pc, 32'h90);
    bus.jump = 0;
    tick();
    bus.branchTaken = 0;
    check("br_pc", bus.pc, 32'h33);

    // ret+call+branch: only the pop happens
    bus.ret = 1; bus.call = 1; bus.branchTaken = 1;
    bus.jumpTarget = 32'h300; bus.branchTarget = 32'h200;
    settle();
    check("prio_rd", {31'd0, bus.readStack}, 32'd1);
    check("prio_wr", {31'd0, bus.writeStack}, 32'd0);
    tick();
    bus.ret = 0; bus.call = 0; bus.branchTaken = 0;
    bus.stall = 1; bus.stackOut = 32'h55;
    settle();
    check("prio_bubble", {31'd0, bus.pcValid}, 32'd0);
    check("prio_pc_held", bus.pc, 32'h33);
    tick();
    check("popstall_valid", {31'd0, bus.pcValid}, 32'd0);
    check("popstall_pc", bus.pc, 32'h33);
    bus.stall = 0;
    tick();
    check("popstall_ret_pc", bus.pc, 32'h55);

    // reset during POP_WAIT abandons the pop
    bus.ret = 1;
    tick();
    bus.ret = 0; reset = 1;
    tick();
    reset = 0;
    settle();
    check("rst_pop_pc", bus.pc, 32'h0);
    check("rst_pop_valid", {31'd0, bus.pcValid}, 32'd1);

    // ret on empty Stack raises the overflow flag during the bubble
    bus.stackOut = 32'h77;
    bus.ret = 1;
    tick();
    bus.ret = 0; bus.stackOverflow = 1;
    tick();
`ifdef PC_TRAP_EN
    check("fault_pc", bus.pc, 32'h100);
    check("fault_trap", {31'd0, bus.trap}, 32'd1);
    tick();
    check("fault_trap_pulse", {31'd0, bus.trap}, 32'd0);
    check("fault_seq", bus.pc, 32'h101);
`else
    check("fault_pc", bus.pc, 32'h77);
    check("fault_trap", {31'd0, bus.trap}, 32'd0);
    tick();
    check("fault_trap_idle", {31'd0, bus.trap}, 32'd0);
    check("fault_seq", bus.pc, 32'h78);
`endif
    bus.stackOverflow = 0;

    // modulo wrap
    bus.jump = 1; bus.jumpTarget = 32'hFFFF_FFFF;
    tick();
    bus.jump = 0;
    settle();
    check("wrap_pre", bus.pc, 32'hFFFF_FFFF);
    check("wrap_push", bus.pushAddr, 32'h0);
    tick();
    check("wrap_pc", bus.pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
